// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of the byte memory port between fetch and microcode data, with bus timeout
package register_types;
  typedef enum logic [1:0] {NONE, OP0, OP1, ACC} name;
endpackage

module mem_port_arbiter #(
  parameter int ADDR_W = 17,
  parameter int TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_req,
  input  logic [ADDR_W-1:0]   fetch_addr,
  output logic                fetch_ack,
  output logic [7:0]          fetch_data,
  input  logic                data_req,
  input  logic                data_we,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [7:0]          data_wdata,
  input  register_types::name data_dest,
  output logic                data_ack,
  output logic                bus_err,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [7:0]          mem_wdata,
  input  logic [7:0]          mem_rdata,
  input  logic                mem_ready,
  output register_types::name mem_dest_select,
  output logic [7:0]          mem_dest,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic gnt_data, last_data, we_q, err, pick_data, any_req, finish, dest_load;
  logic [7:0] cnt, rdata_q;
  register_types::name dest_q;
  always_comb begin
    any_req = fetch_req | data_req;
    pick_data = (fetch_req & data_req) ? !last_data : data_req;
    finish = state == WAIT && (mem_ready || cnt == 8'd1);
    state_n = state == IDLE ? (any_req ? ISSUE : IDLE) :
              state == ISSUE ? WAIT :
              state == WAIT ? (finish ? DONE : WAIT) : IDLE;
    busy = state != IDLE;
    mem_rd = (state == ISSUE || state == WAIT) && !we_q;
    mem_wr = (state == ISSUE || state == WAIT) && we_q;
    fetch_ack = state == DONE && !gnt_data;
    data_ack = state == DONE && gnt_data;
    bus_err = state == DONE && err;
    dest_load = data_ack && !we_q;
    mem_dest_select = dest_load ? dest_q : register_types::NONE;
    mem_dest = dest_load ? rdata_q : 8'h00;
  end
  // last_data resets to DATA so the first contested grant goes to fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt_data <= 1'b0;
      last_data <= 1'b1;
      we_q <= 1'b0;
      err <= 1'b0;
      cnt <= 8'd0;
      rdata_q <= 8'h00;
      fetch_data <= 8'h00;
      mem_addr <= '0;
      mem_wdata <= 8'h00;
      dest_q <= register_types::NONE;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        gnt_data <= pick_data;
        mem_addr <= pick_data ? data_addr : fetch_addr;
        we_q <= pick_data & data_we;
        mem_wdata <= pick_data ? data_wdata : 8'h00;
        dest_q <= pick_data ? data_dest : register_types::NONE;
      end
      if (state == ISSUE) cnt <= 8'(TIMEOUT);
      if (state == WAIT) cnt <= cnt - 8'd1;
      if (finish) begin
        rdata_q <= mem_ready ? mem_rdata : 8'hFF;
        err <= !mem_ready;
        if (!gnt_data) fetch_data <= mem_ready ? mem_rdata : 8'hFF;
      end
      if (state == DONE) begin
        last_data <= gnt_data;
        err <= 1'b0;
      end
    end
  end
endmodule
